i2c_eeprom_slave: RTL and testbench

I2C responder that emulates a small byte-addressable EEPROM (AT24C0x-style, one 8-bit word-address byte) on the board I2C bus, driven by the existing I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, acknowledges its device address and supports byte/page write, current-address read, random read and sequential read from an internal register array. It also exposes a write-strobe port so local logic (e.g. LEDs) can observe stored bytes.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 37 +++
 rtl/i2c_eeprom_slave.sv | 196 +++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, default device address
// and bus levels used for acknowledge signalling.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADR,
    ACK_DEV,
    WADDR,
    ACK_WADDR,
    WDATA,
    ACK_WDATA,
    RDATA,
    RACK,
    DROP
  } i2c_state_e;

  localparam logic [6:0] I2C_DEV_ADDR_DEF = 7'b1010000;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA pins into clk and derives SCL edges and
// START/STOP conditions from the synchronized values.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer, [2] is the history flop for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s    = sda_q[1];
  assign scl_rise =  scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] &  scl_q[2];

  // SCL must be high on both samples, so a coincident SCL edge is never a START/STOP
  assign start_det = ~sda_q[1] &  sda_q[2] & scl_q[1] & scl_q[2];
  assign stop_det  =  sda_q[1] & ~sda_q[2] & scl_q[1] & scl_q[2];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a small byte-addressable EEPROM with one word-address byte.
// Optional write protect input enabled by defining I2C_SLV_WP_EN.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR_DEF,
  parameter int         MEM_DEPTH = 16,
  localparam int        AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
`ifdef I2C_SLV_WP_EN
  input  logic          wp,
`endif
  output logic          busy,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  i2c_state_e    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          sda_oe, sda_oe_nxt;
  logic          busy_nxt;
  logic          ack_en, ack_en_nxt;
  logic          commit;
  logic          wr_block;
  logic [7:0]    rx_byte;
  logic [7:0]    mem [MEM_DEPTH];

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

`ifdef I2C_SLV_WP_EN
  assign wr_block = wp;
`else
  assign wr_block = 1'b0;
`endif

  assign rx_byte = {shreg[6:0], sda_s};
  assign sda     = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shreg_nxt  = shreg;
    ptr_nxt    = ptr;
    sda_oe_nxt = sda_oe;
    busy_nxt   = busy;
    ack_en_nxt = ack_en;
    commit     = 1'b0;
    if (start_det) begin
      state_nxt  = DEVADR;
      cnt_nxt    = 4'd0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      cnt_nxt    = 4'd0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        DEVADR, WADDR, WDATA: begin
          if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              ack_en_nxt = 1'b1;
              if (state == DEVADR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_nxt = ACK_DEV;
                  busy_nxt  = 1'b1;
                end else begin
                  state_nxt = DROP;
                end
              end else if (state == WADDR) begin
                ptr_nxt   = rx_byte[AW-1:0];
                state_nxt = ACK_WADDR;
              end else begin
                ptr_nxt    = ptr + AW'(1);
                ack_en_nxt = ~wr_block;
                commit     = ~wr_block;
                state_nxt  = ACK_WDATA;
              end
            end
          end
        end
        // cnt 8: ack not yet driven; cnt 9: ack clock has risen, release on its fall
        ACK_DEV, ACK_WADDR, ACK_WDATA: begin
          if (scl_rise) begin
            cnt_nxt = 4'd9;
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_nxt = ack_en;
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_nxt    = 4'd0;
            sda_oe_nxt = 1'b0;
            if (state == ACK_DEV && shreg[0]) begin
              shreg_nxt  = mem[ptr];
              sda_oe_nxt = ~mem[ptr][7];
              state_nxt  = RDATA;
            end else if (state == ACK_DEV) begin
              state_nxt = WADDR;
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = RACK;
            end else begin
              shreg_nxt  = {shreg[6:0], shreg[7]};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            ptr_nxt = ptr + AW'(1);
            if (sda_s == I2C_NACK) begin
              state_nxt = DROP;
              busy_nxt  = 1'b0;
            end else begin
              cnt_nxt = 4'd9;
            end
          end else if (scl_fall && cnt == 4'd9) begin
            shreg_nxt  = mem[ptr];
            sda_oe_nxt = ~mem[ptr][7];
            cnt_nxt    = 4'd0;
            state_nxt  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      ack_en  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      sda_oe  <= sda_oe_nxt;
      busy    <= busy_nxt;
      ack_en  <= ack_en_nxt;
      wr_stb  <= commit;
      if (commit) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'd0;
    end else if (commit) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master plus a byte-level EEPROM model.
module tb_i2c_eeprom_slave;

  localparam int Q = 8;

  typedef logic [7:0] bytes_t [$];
  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } commit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       busy;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
`ifdef I2C_SLV_WP_EN
  logic       wp;
`endif

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
`ifdef I2C_SLV_WP_EN
    .wp      (wp),
`endif
    .busy    (busy),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mdl_mem [16];
  logic [3:0] mdl_ptr  = 4'd0;
  logic       wp_on    = 1'b0;
  logic [3:0] hold_a   = 4'd0;
  logic [7:0] hold_d   = 8'd0;
  commit_t    exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Every strobe must match the oldest pending commit; outputs hold in between
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_stb_unexpected actual addr=0x%0h data=0x%0h required=no strobe",
                   wr_addr, wr_data);
        end else begin
          commit_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
          hold_a = e.a;
          hold_d = e.d;
        end
      end else begin
        chk("wr_hold", {20'd0, wr_addr, wr_data}, {20'd0, hold_a, hold_d});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    tick(Q);
    m_low = ~b;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    m_low = 1'b0;
    tick(2 * Q);
    scl = 1'b1;
    tick(Q);
    b = sda;
    tick(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    m_low = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(s);
    acked = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic last);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_in(s);
      d[i] = s;
    end
    bit_out(last);
  endtask

  task automatic addr_phase(input logic [7:0] waddr);
    logic a;
    i2c_start();
    write_byte(8'hA0, a);
    chk("dev_wr_ack", {31'd0, a}, 32'd1);
    chk("busy_after_match", {31'd0, busy}, 32'd1);
    write_byte(waddr, a);
    chk("waddr_ack", {31'd0, a}, 32'd1);
    mdl_ptr = waddr[3:0];
  endtask

  task automatic page_write(input logic [7:0] waddr, input bytes_t data);
    logic a;
    addr_phase(waddr);
    foreach (data[k]) begin
      if (!wp_on) begin
        exp_q.push_back('{a: mdl_ptr, d: data[k]});
        mdl_mem[mdl_ptr] = data[k];
      end
      mdl_ptr++;
      write_byte(data[k], a);
      chk("wdata_ack", {31'd0, a}, {31'd0, ~wp_on});
    end
    i2c_stop();
    tick(4);
    chk("commit_drain", exp_q.size(), 32'd0);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_seq(input logic random, input logic [7:0] waddr, input int n,
                          output bytes_t got);
    logic       a;
    logic [7:0] d;
    got = {};
    if (random) addr_phase(waddr);
    i2c_start();
    write_byte(8'hA1, a);
    chk("dev_rd_ack", {31'd0, a}, 32'd1);
    chk("busy_in_read", {31'd0, busy}, 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(d, k == n - 1);
      chk("rd_data", {24'd0, d}, {24'd0, mdl_mem[mdl_ptr]});
      got.push_back(d);
      mdl_ptr++;
    end
    i2c_stop();
    tick(4);
    chk("busy_after_read", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bytes_t     q;
    bytes_t     got;
    logic       a;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'd0;
    rst   = 1'b1;
    scl   = 1'b1;
    m_low = 1'b0;
`ifdef I2C_SLV_WP_EN
    wp    = 1'b0;
`endif
    tick(4);
    rst = 1'b0;
    tick(4);

    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_wr_stb",  {31'd0, wr_stb},  32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_sda",     {31'd0, sda},     32'd1);

    // single byte write then random read back
    q = {8'h05};
    page_write(8'h0A, q);
    chk("lit_wr_addr", {28'd0, wr_addr}, 32'h0A);
    chk("lit_wr_data", {24'd0, wr_data}, 32'h05);
    read_seq(1'b1, 8'h0A, 1, got);
    chk("lit_rd_0A", {24'd0, got[0]}, 32'h05);

    // foreign device address: NACK and silence afterwards
    i2c_start();
    write_byte(8'hA2, a);
    chk("foreign_nack", {31'd0, a}, 32'd0);
    chk("foreign_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h00, a);
    chk("foreign_no_drive", {31'd0, a}, 32'd0);
    i2c_stop();
    tick(4);

    // page write wrapping past the top of memory
    q = {8'h11, 8'h22, 8'h33};
    page_write(8'h0E, q);
    chk("lit_wrap_addr", {28'd0, wr_addr}, 32'h0);
    read_seq(1'b1, 8'h0E, 3, got);
    chk("lit_seq_0", {24'd0, got[0]}, 32'h11);
    chk("lit_seq_1", {24'd0, got[1]}, 32'h22);
    chk("lit_seq_2", {24'd0, got[2]}, 32'h33);
    read_seq(1'b1, 8'h0F, 1, got);
    chk("lit_rd_0F", {24'd0, got[0]}, 32'h22);
    read_seq(1'b0, 8'h00, 1, got);
    chk("lit_cur_rd", {24'd0, got[0]}, 32'h33);

    // START after four data bits abandons that byte
    addr_phase(8'h03);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    q = {8'h77};
    page_write(8'h03, q);
    read_seq(1'b1, 8'h03, 1, got);
    chk("lit_rd_03", {24'd0, got[0]}, 32'h77);
    chk("lit_rd_04_mdl", {24'd0, mdl_mem[4]}, 32'h00);

    // reset while the responder drives a 0 data bit
    addr_phase(8'h03);
    i2c_start();
    write_byte(8'hA1, a);
    chk("rd_ack_before_rst", {31'd0, a}, 32'd1);
    tick(Q);
    chk("sda_driven_msb0", {31'd0, sda}, 32'd0);
    rst    = 1'b1;
    exp_q.delete();
    hold_a = 4'd0;
    hold_d = 8'd0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'd0;
    mdl_ptr = 4'd0;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_sda",     {31'd0, sda},     32'd1);
    chk("rst_mid_busy",    {31'd0, busy},    32'd0);
    chk("rst_mid_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_mid_wr_data", {24'd0, wr_data}, 32'd0);
    i2c_stop();
    tick(4);
    read_seq(1'b1, 8'h0E, 1, got);
    chk("lit_cleared_0E", {24'd0, got[0]}, 32'h00);
    read_seq(1'b1, 8'h03, 1, got);
    chk("lit_cleared_03", {24'd0, got[0]}, 32'h00);

`ifdef I2C_SLV_WP_EN
    q = {8'h3C};
    page_write(8'h02, q);
    wp    = 1'b1;
    wp_on = 1'b1;
    q = {8'h5A};
    page_write(8'h02, q);
    wp    = 1'b0;
    wp_on = 1'b0;
    read_seq(1'b1, 8'h02, 2, got);
    chk("lit_wp_kept", {24'd0, got[0]}, 32'h3C);
    chk("lit_wp_next", {24'd0, got[1]}, 32'h00);
`endif

    tick(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
